fir_stream_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one 15-tap complex FIR between two AXI-Stream sources
//  (e.g. forward/reflected ADL5960 IQ channels). Grants one source per packet (tlast-delimited),

---
 rtl/fir_stream_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_fir_stream_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_arbiter.sv
`timescale 1ns/1ps
// fir_stream_arbiter
// Packet-level round-robin arbiter that shares one complex FIR between two
// AXI-Stream sources. A source owns the output for one whole packet
// (tlast-delimited). After that packet the output is held idle for
// FLUSH_CYCLES so the FIR tap pipeline can drain. m00_axis_tid tags the
// granted channel. The data path is a zero-latency combinational passthrough.
module fir_stream_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int FLUSH_CYCLES       = 16,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  // channel 0
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  // channel 1
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
  input  logic [(C_AXIS_TDATA_WIDTH/8)-1:0] s01_axis_tstrb,
  input  logic                              s01_axis_tvalid,
  input  logic                              s01_axis_tlast,
  output logic                              s01_axis_tready,
  // shared output towards the FIR
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  output logic                              m00_axis_tid,
  input  logic                              m00_axis_tready,
  // status
  output logic [CNT_WIDTH-1:0]              ch0_pkt_count,
  output logic [CNT_WIDTH-1:0]              ch1_pkt_count,
  output logic                              busy
);

  // Flush counter only needs to hold FLUSH_CYCLES-1; keep at least one bit.
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  logic          clk;
  logic          srst;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;

  // pkt_done[x]: the tlast beat of channel x is being accepted this cycle
  logic [1:0]    pkt_done;

  assign clk  = s00_axis_aclk;
  assign srst = s00_axis_areset;

  assign pkt_done[0] = (state_q == GRANT0) & s00_axis_tvalid & m00_axis_tready & s00_axis_tlast;
  assign pkt_done[1] = (state_q == GRANT1) & s01_axis_tvalid & m00_axis_tready & s01_axis_tlast;

  // State, round-robin pointer and flush counter registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // channel 0 wins the first tie after reset
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold grant until tlast, then drain
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    flush_cnt_d  = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s00_axis_tvalid && s01_axis_tvalid) begin
          // tie: the channel that was not served last goes next
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (s00_axis_tvalid) begin
          state_d = GRANT0;
        end else if (s01_axis_tvalid) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (pkt_done[0]) begin
          state_d      = FLUSH;
          flush_cnt_d  = FW'(FLUSH_CYCLES - 1);
          last_grant_d = 1'b0;
        end
      end
      GRANT1: begin
        if (pkt_done[1]) begin
          state_d      = FLUSH;
          flush_cnt_d  = FW'(FLUSH_CYCLES - 1);
          last_grant_d = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux: passthrough for the granted channel, everything quiet otherwise
  always_comb begin
    m00_axis_tdata  = '0;
    m00_axis_tstrb  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    m00_axis_tid    = last_grant_q;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    unique case (state_q)
      GRANT0: begin
        m00_axis_tdata  = s00_axis_tdata;
        m00_axis_tstrb  = s00_axis_tstrb;
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tlast  = s00_axis_tlast;
        m00_axis_tid    = 1'b0;
        // tready is driven only by the downstream, never by this channel's tvalid
        s00_axis_tready = m00_axis_tready;
      end
      GRANT1: begin
        m00_axis_tdata  = s01_axis_tdata;
        m00_axis_tstrb  = s01_axis_tstrb;
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tlast  = s01_axis_tlast;
        m00_axis_tid    = 1'b1;
        s01_axis_tready = m00_axis_tready;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // Per-channel completed-packet counters; they wrap naturally at 2^CNT_WIDTH
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

      // Increment on the accepted tlast beat of this channel
      always_comb begin
        cnt_d = cnt_q;
        if (pkt_done[gi]) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      // Counter register
      always_ff @(posedge clk) begin
        if (srst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign ch0_pkt_count = g_cnt[0].cnt_q;
  assign ch1_pkt_count = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_fir_stream_arbiter.sv
`timescale 1ns/1ps
// Bench for fir_stream_arbiter: per-channel scoreboards filled when beats are
// driven and drained when m00 hands a beat over, an arbitration vector table,
// and hand-written sequences for stall, reset-abort, packet gap and wrap.
module tb_fir_stream_arbiter;

  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int FL = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic [DW-1:0] s00_axis_tdata,  s01_axis_tdata;
  logic [SW-1:0] s00_axis_tstrb,  s01_axis_tstrb;
  logic          s00_axis_tvalid, s01_axis_tvalid;
  logic          s00_axis_tlast,  s01_axis_tlast;
  logic          s00_axis_tready, s01_axis_tready;
  logic [DW-1:0] m00_axis_tdata;
  logic [SW-1:0] m00_axis_tstrb;
  logic          m00_axis_tvalid, m00_axis_tlast, m00_axis_tid, m00_axis_tready;
  logic [CW-1:0] ch0_pkt_count, ch1_pkt_count;
  logic          busy;

  // second instance: 4-bit counters and the minimum flush length
  logic [DW-1:0] w_s0_tdata, w_s1_tdata, w_m_tdata;
  logic [SW-1:0] w_s0_tstrb, w_s1_tstrb, w_m_tstrb;
  logic          w_s0_tvalid, w_s1_tvalid, w_s0_tlast, w_s1_tlast;
  logic          w_s0_tready, w_s1_tready;
  logic          w_m_tvalid, w_m_tlast, w_m_tid, w_m_tready, w_busy;
  logic [3:0]    w_cnt0, w_cnt1;

  fir_stream_arbiter #(.C_AXIS_TDATA_WIDTH(DW), .FLUSH_CYCLES(FL), .CNT_WIDTH(CW)) u_dut (
    .s00_axis_aclk(clk), .s00_axis_areset(areset),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tstrb(s00_axis_tstrb),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tlast(s00_axis_tlast),
    .s00_axis_tready(s00_axis_tready),
    .s01_axis_tdata(s01_axis_tdata), .s01_axis_tstrb(s01_axis_tstrb),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tlast(s01_axis_tlast),
    .s01_axis_tready(s01_axis_tready),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tstrb(m00_axis_tstrb),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tid(m00_axis_tid), .m00_axis_tready(m00_axis_tready),
    .ch0_pkt_count(ch0_pkt_count), .ch1_pkt_count(ch1_pkt_count), .busy(busy)
  );

  fir_stream_arbiter #(.C_AXIS_TDATA_WIDTH(DW), .FLUSH_CYCLES(1), .CNT_WIDTH(4)) u_wrap (
    .s00_axis_aclk(clk), .s00_axis_areset(areset),
    .s00_axis_tdata(w_s0_tdata), .s00_axis_tstrb(w_s0_tstrb),
    .s00_axis_tvalid(w_s0_tvalid), .s00_axis_tlast(w_s0_tlast),
    .s00_axis_tready(w_s0_tready),
    .s01_axis_tdata(w_s1_tdata), .s01_axis_tstrb(w_s1_tstrb),
    .s01_axis_tvalid(w_s1_tvalid), .s01_axis_tlast(w_s1_tlast),
    .s01_axis_tready(w_s1_tready),
    .m00_axis_tdata(w_m_tdata), .m00_axis_tstrb(w_m_tstrb),
    .m00_axis_tvalid(w_m_tvalid), .m00_axis_tlast(w_m_tlast),
    .m00_axis_tid(w_m_tid), .m00_axis_tready(w_m_tready),
    .ch0_pkt_count(w_cnt0), .ch1_pkt_count(w_cnt1), .busy(w_busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  beat_t exp_q0[$];
  beat_t exp_q1[$];
  int    tid_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat_count = 0;
  bit in_pkt = 0;
  bit gap_en = 0;
  int last_tlast_cyc = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: scoreboard pop, packet-gap measurement, tready exclusivity
  always @(negedge clk) begin
    beat_t e;
    chk("tready_exclusive", {63'd0, s00_axis_tready & s01_axis_tready}, 64'd0);
    if (m00_axis_tvalid && m00_axis_tready) begin
      beat_count++;
      if ((m00_axis_tid == 1'b0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got ch%0d data 0x%0h, expected no beat", m00_axis_tid, m00_axis_tdata);
      end else begin
        e = (m00_axis_tid == 1'b0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("beat_data", 64'(m00_axis_tdata), 64'(e.data));
        chk("beat_strb", 64'(m00_axis_tstrb), 64'(e.strb));
        chk("beat_last", 64'(m00_axis_tlast), 64'(e.last));
      end
      if (!in_pkt && gap_en && last_tlast_cyc >= 0)
        chk("packet_gap", 64'(cyc - last_tlast_cyc), 64'(FL + 2));
      $display("beat ch%0d data=0x%08h strb=0x%0h last=%0d cycle=%0d",
               m00_axis_tid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, cyc);
      in_pkt = !m00_axis_tlast;
      if (m00_axis_tlast) begin
        last_tlast_cyc = cyc;
        tid_log.push_back(int'(m00_axis_tid));
      end
    end
  end

  task automatic send_pkt(input int ch, input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
    beat_t b;
    bit    ok;
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i) * step;
      b.strb = 4'hF ^ 4'(i);
      b.last = (i == n - 1);
      if (ch == 0) begin
        exp_q0.push_back(b);
        s00_axis_tdata = b.data; s00_axis_tstrb = b.strb;
        s00_axis_tlast = b.last; s00_axis_tvalid = 1'b1;
      end else begin
        exp_q1.push_back(b);
        s01_axis_tdata = b.data; s01_axis_tstrb = b.strb;
        s01_axis_tlast = b.last; s01_axis_tvalid = 1'b1;
      end
      ok = 1'b0;
      for (int t = 0; t < 1000; t++) begin
        @(negedge clk);
        if ((ch == 0) ? s00_axis_tready : s01_axis_tready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL send_timeout ch%0d beat %0d: tready got 0, expected 1", ch, i);
      end
      @(posedge clk);
      #1;
    end
    if (ch == 0) begin
      s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0; s00_axis_tdata = '0; s00_axis_tstrb = '0;
    end else begin
      s01_axis_tvalid = 1'b0; s01_axis_tlast = 1'b0; s01_axis_tdata = '0; s01_axis_tstrb = '0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy got 1, expected 0");
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s00_axis_tdata = '0; s00_axis_tstrb = '0; s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0;
    s01_axis_tdata = '0; s01_axis_tstrb = '0; s01_axis_tvalid = 1'b0; s01_axis_tlast = 1'b0;
    w_s0_tdata = '0; w_s0_tstrb = '0; w_s0_tvalid = 1'b0; w_s0_tlast = 1'b0;
    w_s1_tdata = '0; w_s1_tstrb = '0; w_s1_tvalid = 1'b0; w_s1_tlast = 1'b0;
    m00_axis_tready = 1'b1;
    w_m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    tid_log.delete();
    in_pkt = 1'b0;
    last_tlast_cyc = -1;
  endtask

  typedef struct {
    bit v0;
    bit v1;
    int first_tid;
    int cnt0;
    int cnt1;
  } arb_vec_t;

  arb_vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, expected done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    int  start;
    int  prev;
    bit  a0, a1;
    bit  ok;

    // ---------------- reset state ----------------
    do_reset();
    @(negedge clk);
    chk("rst_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("rst_tdata",  64'(m00_axis_tdata),  64'd0);
    chk("rst_tstrb",  64'(m00_axis_tstrb),  64'd0);
    chk("rst_tlast",  64'(m00_axis_tlast),  64'd0);
    chk("rst_tready0", 64'(s00_axis_tready), 64'd0);
    chk("rst_tready1", 64'(s01_axis_tready), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_cnt0",   64'(ch0_pkt_count), 64'd0);
    chk("rst_cnt1",   64'(ch1_pkt_count), 64'd0);

    // ---------------- single 4-beat packet, then flush window ----------------
    send_pkt(0, 4, 32'h0001_0002, 32'h0002_0002);
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!busy) break;
      if (n == 0) chk("tid_in_flush", 64'(m00_axis_tid), 64'd0);
      if (m00_axis_tvalid) chk("flush_tvalid", 64'(m00_axis_tvalid), 64'd0);
      n++;
    end
    chk("flush_len", 64'(n), 64'(FL));
    chk("t1_cnt0", 64'(ch0_pkt_count), 64'd1);
    chk("t1_tid_log", 64'(tid_log.size() == 1 ? tid_log[0] : 9), 64'd0);

    // ---------------- both valid from reset: ch0, ch1, ch0 ----------------
    do_reset();
    fork
      begin
        send_pkt(0, 3, 32'hA100_0000, 32'h1);
        send_pkt(0, 3, 32'hA300_0000, 32'h1);
      end
      send_pkt(1, 3, 32'hA200_0000, 32'h1);
    join
    wait_idle();
    chk("rr_order_n", 64'(tid_log.size()), 64'd3);
    chk("rr_order_0", 64'(tid_log.size() > 0 ? tid_log[0] : 9), 64'd0);
    chk("rr_order_1", 64'(tid_log.size() > 1 ? tid_log[1] : 9), 64'd1);
    chk("rr_order_2", 64'(tid_log.size() > 2 ? tid_log[2] : 9), 64'd0);
    chk("rr_cnt0", 64'(ch0_pkt_count), 64'd2);
    chk("rr_cnt1", 64'(ch1_pkt_count), 64'd1);

    // ---------------- downstream stall mid-packet ----------------
    start = beat_count;
    fork
      send_pkt(0, 6, 32'hA000_0000, 32'h1);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_pkt(1, 2, 32'hB000_0000, 32'h1);
      end
      begin
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
          @(posedge clk);
          if (beat_count >= start + 2) begin
            ok = 1'b1;
            break;
          end
        end
        chk("stall_reached", 64'(ok), 64'd1);
        #1;
        m00_axis_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_tready0", 64'(s00_axis_tready), 64'd0);
          chk("stall_tready1", 64'(s01_axis_tready), 64'd0);
          chk("stall_tvalid",  64'(m00_axis_tvalid), 64'd1);
          chk("stall_tdata",   64'(m00_axis_tdata),  64'h0000_0000_A000_0002);
        end
        @(posedge clk);
        #1;
        m00_axis_tready = 1'b1;
      end
    join
    wait_idle();
    chk("stall_cnt0", 64'(ch0_pkt_count), 64'd3);
    chk("stall_cnt1", 64'(ch1_pkt_count), 64'd2);

    // ---------------- reset on beat 2 of a 6-beat packet ----------------
    exp_q0.push_back('{data: 32'hC000_0000, strb: 4'hF, last: 1'b0});
    s00_axis_tdata = 32'hC000_0000; s00_axis_tstrb = 4'hF;
    s00_axis_tlast = 1'b0; s00_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (s00_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_beat1", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    // beat 2 is visible on m00 during the cycle reset is asserted
    exp_q0.push_back('{data: 32'hC000_0001, strb: 4'hE, last: 1'b0});
    s00_axis_tdata = 32'hC000_0001; s00_axis_tstrb = 4'hE;
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    s00_axis_tvalid = 1'b0; s00_axis_tdata = '0; s00_axis_tstrb = '0;
    @(negedge clk);
    in_pkt = 1'b0;
    chk("abort_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("abort_tdata",  64'(m00_axis_tdata),  64'd0);
    chk("abort_tready0", 64'(s00_axis_tready), 64'd0);
    chk("abort_busy",   64'(busy), 64'd0);
    chk("abort_cnt0",   64'(ch0_pkt_count), 64'd0);
    chk("abort_cnt1",   64'(ch1_pkt_count), 64'd0);
    chk("abort_queue",  64'(exp_q0.size()), 64'd0);
    send_pkt(0, 2, 32'hD000_0000, 32'h1);
    wait_idle();
    chk("abort_after_cnt0", 64'(ch0_pkt_count), 64'd1);

    // ---------------- arbitration vector table ----------------
    tbl[0] = '{1, 1, 0, 1, 1};
    tbl[1] = '{1, 0, 0, 2, 1};
    tbl[2] = '{1, 1, 1, 3, 2};
    tbl[3] = '{0, 1, 1, 3, 3};
    tbl[4] = '{1, 1, 0, 4, 4};
    tbl[5] = '{0, 1, 1, 4, 5};
    tbl[6] = '{0, 1, 1, 4, 6};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      a0 = tbl[i].v0;
      a1 = tbl[i].v1;
      tid_log.delete();
      fork
        begin
          if (a0) send_pkt(0, 1, 32'hE000_0000 + DW'(i), 32'h1);
        end
        begin
          if (a1) send_pkt(1, 1, 32'hF000_0000 + DW'(i), 32'h1);
        end
      join
      wait_idle();
      chk("arb_first_tid", 64'(tid_log.size() > 0 ? tid_log[0] : 9), 64'(tbl[i].first_tid));
      chk("arb_cnt0", 64'(ch0_pkt_count), 64'(tbl[i].cnt0));
      chk("arb_cnt1", 64'(ch1_pkt_count), 64'(tbl[i].cnt1));
    end

    // ---------------- ch1 alone, 5 back-to-back packets ----------------
    tid_log.delete();
    last_tlast_cyc = -1;
    in_pkt = 1'b0;
    gap_en = 1'b1;
    for (int p = 0; p < 5; p++) send_pkt(1, 3, 32'h5000_0000 + DW'(p << 8), 32'h1);
    wait_idle();
    gap_en = 1'b0;
    chk("b2b_npkts", 64'(tid_log.size()), 64'd5);
    for (int p = 0; p < 5; p++) chk("b2b_tid", 64'(p < tid_log.size() ? tid_log[p] : 9), 64'd1);
    chk("b2b_cnt1", 64'(ch1_pkt_count), 64'd11);

    // ---------------- counter wrap and 1-cycle flush (second instance) ----------------
    do_reset();
    w_s0_tvalid = 1'b1;
    w_s0_tlast  = 1'b1;
    w_s0_tstrb  = 4'hF;
    w_s0_tdata  = 32'd0;
    prev = -1;
    for (int k = 1; k <= 17; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (w_s0_tready) begin
          ok = 1'b1;
          break;
        end
      end
      chk("wrap_accept", 64'(ok), 64'd1);
      chk("wrap_tid", 64'(w_m_tid), 64'd0);
      if (prev >= 0) chk("wrap_gap", 64'(cyc - prev), 64'd3);
      prev = cyc;
      @(posedge clk);
      #1;
      w_s0_tdata = DW'(k);
      @(negedge clk);
      chk("wrap_count", 64'(w_cnt0), 64'(k % 16));
      $display("wrap packet %0d count=%0d", k, w_cnt0);
    end
    w_s0_tvalid = 1'b0;
    w_s0_tlast  = 1'b0;

    chk("end_queue0", 64'(exp_q0.size()), 64'd0);
    chk("end_queue1", 64'(exp_q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
